// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the 16-bit multicycle CPU.
// Holds PC and the instruction register, and runs a level-based req/ready
// read of instruction memory. stall freezes the controller while a fetch is
// outstanding. fault flags a fetch that timed out waiting for mem_ready.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IRWrite,
  input  logic [15:0] Result,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] PC,
  output logic [15:0] Instr,
  output logic        stall,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [15:0] pc_reg;
  logic [15:0] instr_reg, instr_next;
  logic [15:0] addr_reg, addr_next;
  logic        req_reg, req_next;
  logic        fault_reg, fault_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [7:0]  cnt_plus;

  assign cnt_plus = cnt_reg + 8'd1;

  // Program counter: loaded from the result bus whenever the controller asks,
  // independent of any fetch in flight (mem_addr keeps its own copy).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else if (PCWrite) begin
      pc_reg <= Result;
    end
  end

  // Fetch FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      instr_reg <= 16'h0000;
      addr_reg  <= RESET_PC;
      req_reg   <= 1'b0;
      fault_reg <= 1'b0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      instr_reg <= instr_next;
      addr_reg  <= addr_next;
      req_reg   <= req_next;
      fault_reg <= fault_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: request is registered so mem_req/mem_addr stay stable
  // for the whole handshake; the timeout fires on the WAIT cycle whose
  // increment would bring the counter to TIMEOUT.
  always_comb begin
    state_next = state_reg;
    instr_next = instr_reg;
    addr_next  = addr_reg;
    req_next   = req_reg;
    fault_next = fault_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (IRWrite) begin
          addr_next  = pc_reg;
          req_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          instr_next = mem_rdata;
          req_next   = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next   = 8'd0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          instr_next = mem_rdata;
          req_next   = 1'b0;
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (cnt_plus == TIMEOUT_CNT) begin
          fault_next = 1'b1;
          req_next   = 1'b0;
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_plus;
        end
      end
      default: begin
        req_next   = 1'b0;
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  // Stall is combinational so the controller freezes in the IRWrite cycle.
  always_comb begin
    stall = (state_reg != IDLE) || ((state_reg == IDLE) && IRWrite);
  end

  assign mem_req  = req_reg;
  assign mem_addr = addr_reg;
  assign PC       = pc_reg;
  assign Instr    = instr_reg;
  assign fault    = fault_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an expected-instruction scoreboard.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, IRWrite;
  logic [15:0] Result, mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic [15:0] mem_addr, PC, Instr;
  logic        stall, fault;

  int          n_cmp = 0;
  int          n_err = 0;
  int          captures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_instr = 16'h0000;
  logic        exp_fault = 1'b0;

  instr_fetch_unit #(.RESET_PC(16'h0010), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .Result(Result), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .PC(PC), .Instr(Instr),
    .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && mem_ready) captures <= captures + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch, called just after a rising edge. lat = index of the request
  // cycle (0 = REQ cycle) in which mem_ready is raised; large = never.
  task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] data, input int lat,
                       input logic pcw_start, input logic [15:0] res_start,
                       input logic pcw_mid, input logic [15:0] res_mid,
                       input logic irw_mid, input logic expect_fault,
                       output int req_cycles, output int stall_cycles);
    logic        done;
    logic [15:0] exp_instr;
    if (expect_fault) exp_q.push_back(last_instr);
    else              exp_q.push_back(data);
    IRWrite   = 1'b1;
    PCWrite   = pcw_start;
    Result    = res_start;
    mem_rdata = data;
    mem_ready = 1'b0;
    #1;
    chk("stall_on_irwrite", {15'd0, stall}, 16'd1);
    stall_cycles = 1;
    @(posedge clk); #1;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    req_cycles = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      chk("mem_req_held", {15'd0, mem_req}, 16'd1);
      chk("mem_addr_held", mem_addr, exp_addr);
      if (stall) stall_cycles++;
      req_cycles++;
      mem_ready = (c == lat);
      if (c == 1) begin
        PCWrite = pcw_mid;
        Result  = res_mid;
        IRWrite = irw_mid;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      if (!mem_req) done = 1'b1;
    end
    chk("fetch_completes", {15'd0, done}, 16'd1);
    if (expect_fault) exp_fault = 1'b1;
    chk("fault_flag", {15'd0, fault}, {15'd0, exp_fault});
    chk("stall_after", {15'd0, stall}, 16'd0);
    chk("queue_nonempty", {15'd0, (exp_q.size() > 0)}, 16'd1);
    if (exp_q.size() > 0) begin
      exp_instr = exp_q.pop_front();
      chk("instr_capture", Instr, exp_instr);
      last_instr = exp_instr;
    end
  endtask

  initial begin
    int rc, sc, cap0;
    rst = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0; Result = 16'h0000;
    mem_rdata = 16'h0000; mem_ready = 1'b0;

    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", PC, 16'h0010);
    chk("rst_addr", mem_addr, 16'h0010);
    chk("rst_instr", Instr, 16'h0000);
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_fault", {15'd0, fault}, 16'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_pc", PC, 16'h0010);
    chk("post_rst_req", {15'd0, mem_req}, 16'd0);
    $display("step reset: PC=%h Instr=%h", PC, Instr);

    // 2. zero-wait fetch
    fetch(16'h0010, 16'h4A21, 0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, rc, sc);
    chk("zw_req_cycles", 16'(rc), 16'd1);
    chk("zw_stall_cycles", 16'(sc), 16'd2);
    $display("fetch zero-wait: Instr=%h req_cycles=%0d stall_cycles=%0d", Instr, rc, sc);

    // mem_ready ignored in IDLE
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("idle_ready_ignored", Instr, 16'h4A21);
    chk("idle_no_req", {15'd0, mem_req}, 16'd0);
    $display("idle ready pulse: Instr=%h", Instr);

    // 3. wait states
    fetch(16'h0010, 16'hC005, 3, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, rc, sc);
    chk("ws_req_cycles", 16'(rc), 16'd4);
    chk("ws_stall_cycles", 16'(sc), 16'd5);
    $display("fetch wait-states: Instr=%h req_cycles=%0d", Instr, rc);

    // 4. PC updates during fetch
    fetch(16'h0010, 16'h1234, 2, 1'b1, 16'h0011, 1'b1, 16'h0012, 1'b0, 1'b0, rc, sc);
    chk("pcw_final_pc", PC, 16'h0012);
    $display("fetch with PCWrite: Instr=%h PC=%h", Instr, PC);

    // 5. timeout, then a normal fetch with fault still set
    fetch(16'h0012, 16'hBEEF, 1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, rc, sc);
    chk("to_req_cycles", 16'(rc), 16'd5);
    chk("to_req_dropped", {15'd0, mem_req}, 16'd0);
    $display("fetch timeout: fault=%b Instr=%h req_cycles=%0d", fault, Instr, rc);
    fetch(16'h0012, 16'h0A0A, 0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, rc, sc);
    $display("fetch after fault: fault=%b Instr=%h", fault, Instr);

    // 6. IRWrite during WAIT is ignored
    cap0 = captures;
    fetch(16'h0012, 16'h5555, 3, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, rc, sc);
    @(posedge clk); #1;
    chk("ign_one_capture", 16'(captures - cap0), 16'd1);
    chk("ign_no_second_req", {15'd0, mem_req}, 16'd0);
    chk("ign_idle", {15'd0, stall}, 16'd0);
    $display("fetch with ignored strobe: Instr=%h captures=%0d", Instr, captures - cap0);

    // 7. asynchronous reset mid-fetch
    IRWrite = 1'b1; mem_rdata = 16'h7777;
    @(posedge clk); #1;
    IRWrite = 1'b0;
    chk("ar_req_before", {15'd0, mem_req}, 16'd1);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("ar_req", {15'd0, mem_req}, 16'd0);
    chk("ar_pc", PC, 16'h0010);
    chk("ar_addr", mem_addr, 16'h0010);
    chk("ar_instr", Instr, 16'h0000);
    chk("ar_stall", {15'd0, stall}, 16'd0);
    chk("ar_fault", {15'd0, fault}, 16'd0);
    $display("async reset: PC=%h mem_req=%b fault=%b", PC, mem_req, fault);
    exp_fault = 1'b0; last_instr = 16'h0000;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ar_no_resume", {15'd0, mem_req}, 16'd0);
    fetch(16'h0010, 16'h9ABC, 1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, rc, sc);
    chk("ar_fetch_cycles", 16'(rc), 16'd2);
    $display("fetch after reset: Instr=%h", Instr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Holds the program counter and instruction register for the 16-bit multicycle CPU, and performs the instruction-memory read for each fetch. It sits directly upstream of the controller FSM: it consumes the controller's PCWrite/IRWrite strobes and the datapath Result bus, and it supplies Instr to the controller. Instruction memory may take a variable number of cycles, so the block runs a req/ready handshake and raises a stall to freeze the controller until the fetched word is captured.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
TIMEOUT, 15, max cycles spent in WAIT before fault; legal range 1..255

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
PCWrite  input  1  controller strobe: load PC from Result
IRWrite  input  1  controller strobe: start instruction fetch at current PC
Result  input  16  datapath result bus (next PC value)
mem_rdata  input  16  instruction memory read data
mem_ready  input  1  memory handshake: rdata valid this cycle
mem_req  output  1  memory read request
mem_addr  output  16  memory read address
PC  output  16  current program counter
Instr  output  16  instruction register
stall  output  1  high while a fetch is outstanding; controller holds state
fault  output  1  sticky fetch-timeout flag

Behaviour:
- Reset (rst=0, asynchronous): PC=RESET_PC, Instr=16'h0000, mem_req=0, mem_addr=RESET_PC, stall=0, fault=0, FSM=IDLE, timeout counter=0. Outputs change without waiting for clk. A fetch in flight is aborted and its data discarded.
- FSM states: IDLE, REQ, WAIT.
- IDLE: if IRWrite=1, latch mem_addr<=PC, set mem_req<=1, and go to REQ. Otherwise stay in IDLE.
- REQ: lasts one cycle, with mem_req=1. If mem_ready=1, capture Instr<=mem_rdata, drop mem_req, and go to IDLE. This is the minimum fetch latency: Instr updates 2 edges after the IRWrite edge. Otherwise go to WAIT with the counter cleared.
- WAIT: mem_req stays 1 and mem_addr is held stable. If mem_ready=1, capture Instr, drop mem_req, and go to IDLE. Otherwise increment the counter. When the counter reaches TIMEOUT, set fault=1, drop mem_req, leave Instr unchanged, and go to IDLE.
- stall = (state != IDLE) || (state==IDLE && IRWrite). This is combinational, so the controller sees stall in the same cycle it issues IRWrite.
- The handshake is level-based. mem_ready is ignored in IDLE. mem_addr and mem_req must not change while mem_req=1 and mem_ready=0.
- PCWrite: PC<=Result on the clock edge, in any FSM state. It does not affect mem_addr once latched, so an in-flight fetch reads the old PC.
- Simultaneous IRWrite and PCWrite in IDLE: mem_addr latches the pre-update PC, and PC takes Result on the same edge.
- IRWrite while not IDLE is ignored (no queueing). Instr changes only on a successful capture.
- fault is sticky until reset. The FSM continues to accept new fetches after a fault.
- Widths: PC and mem_addr are 16-bit and never arithmetic inside this block. The counter is 8-bit, and compare is counter==TIMEOUT.

Test Plan:
1. Reset: hold rst=0 with RESET_PC=16'h0010, then release -> PC=0010, Instr=0000, mem_req=0, stall=0, fault=0. Assert rst=0 mid-cycle -> outputs reset before the next clk edge.
2. Zero-wait fetch: mem_ready tied 1, PC=0010, pulse IRWrite with mem_rdata=16'h4A21 -> mem_req=1 and mem_addr=0010 for exactly 1 cycle. Instr=4A21 after the second edge. stall high for 2 cycles.
3. Wait states: mem_ready rises 3 cycles after the request with rdata=16'hC005 -> mem_addr stays 0010 throughout, Instr=C005 on the ready edge, and stall drops the next cycle.
4. PC update during fetch: PCWrite=1 with Result=16'h0011 in the same cycle as IRWrite, then PCWrite=1 with Result=0012 in WAIT -> mem_addr stays 0010 and PC=0012 at completion.
5. Timeout: TIMEOUT=4 with mem_ready held 0 -> fault=1 after 1 REQ cycle plus 4 WAIT cycles, mem_req=0, Instr unchanged. The next IRWrite starts a fetch normally, and fault stays 1.
6. Ignored strobe: pulse IRWrite again during WAIT -> no second request. Exactly one capture occurs, and the FSM returns to IDLE.
